load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/core_pkg.sv | 59 +++++
 rtl/lsu_align.sv | 42 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: load/store funct3 encodings, LSU state encoding and
// legality/alignment helpers used by the load/store unit.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef logic [4:0] register_file_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_op_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Low EA bits that must be zero for an access of 2^size bytes.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  function automatic logic load_legal(input logic [2:0] f3, input logic xlen64);
    case (f3)
      LB, LH, LW, LBU, LHU: load_legal = 1'b1;
      LD, LWU:              load_legal = xlen64;
      default:              load_legal = 1'b0;
    endcase
  endfunction

  function automatic logic store_legal(input logic [2:0] f3, input logic xlen64);
    case (f3)
      SB, SH, SW: store_legal = 1'b1;
      SD:         store_legal = xlen64;
      default:    store_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: stores shift data up into the EA lane; loads shift the
// addressed lane down and sign- or zero-extend it to XLEN.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic                         store,
  input  logic [$clog2(XLEN/8)-1:0]    lane,
  input  logic [1:0]                   size,
  input  logic                         uns,
  input  logic [XLEN-1:0]              data_in,
  output logic [XLEN-1:0]              data_out
);

  localparam int LANE_W = $clog2(XLEN/8);
  localparam int KW     = $clog2(XLEN) + 1;

  logic [LANE_W+2:0] shamt;
  logic [KW-1:0]     k;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   left;

  // Extension is done by parking the field at the MSB and shifting back down.
  always_comb begin
    shamt = {lane, 3'b000};
    case (size)
      2'd0:    k = KW'(XLEN - 8);
      2'd1:    k = KW'(XLEN - 16);
      2'd2:    k = KW'(XLEN - 32);
      default: k = '0;
    endcase
    shifted = store ? (data_in << shamt) : (data_in >> shamt);
    left    = shifted << k;
    if (store) begin
      data_out = shifted;
    end else if (uns) begin
      data_out = left >> k;
    end else begin
      data_out = $unsigned($signed(left) >>> k);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: computes EA, checks legality and
// alignment, runs one memory transaction and emits one response pulse.
//
// state | meaning
// IDLE  | ready for a request
// REQ   | memory request presented, waiting for grant
// WAIT  | load granted, waiting for read data
// RESP  | one-cycle writeback / done / exception pulse
module load_store_unit
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_load_i,
  input  logic                 req_store_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [XLEN-1:0]      req_base_i,
  input  logic [XLEN-1:0]      req_offset_i,
  input  logic [XLEN-1:0]      req_wdata_i,
  input  register_file_t       req_rd_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [XLEN-1:0]      mem_rdata_i,
  output logic                 wb_valid_o,
  output register_file_t       wb_rd_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 done_o,
  output logic                 exc_o,
  output logic                 exc_cause_o,
  output logic [XLEN-1:0]      exc_addr_o,
  output logic                 busy_o
);

  localparam int BW     = XLEN / 8;
  localparam int LANE_W = $clog2(BW);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] ea_q, wdata_q, rdata_q;
  logic [2:0]      f3_q;
  logic            store_q, exc_q, cause_q;
  register_file_t  rd_q;

  logic [XLEN-1:0] ea, store_lanes, load_lanes;
  logic            accept, illegal, misaligned, in_req;
  logic [BW-1:0]   size_be;

  assign ea         = req_base_i + req_offset_i;
  assign accept     = req_valid_i && (state_q == IDLE) && (req_load_i || req_store_i);
  assign illegal    = (req_load_i && req_store_i) ||
                      (req_load_i ? !load_legal(req_funct3_i, XLEN == 64)
                                  : !store_legal(req_funct3_i, XLEN == 64));
  assign misaligned = |(ea[2:0] & align_mask(req_funct3_i[1:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)       state_d = (illegal || misaligned) ? RESP : REQ;
      REQ:  if (mem_gnt_i)    state_d = store_q ? RESP : WAIT;
      WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        ea_q    <= ea;
        wdata_q <= req_wdata_i;
        f3_q    <= req_funct3_i;
        store_q <= req_store_i;
        exc_q   <= illegal || misaligned;
        cause_q <= illegal;
        rd_q    <= req_rd_i;
      end
      if (state_q == WAIT && mem_rvalid_i) rdata_q <= load_lanes;
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'd0:    size_be = BW'(1);
      2'd1:    size_be = BW'(3);
      2'd2:    size_be = BW'(15);
      default: size_be = '1;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_store_align (
    .store    (1'b1),
    .lane     (ea_q[LANE_W-1:0]),
    .size     (f3_q[1:0]),
    .uns      (f3_q[2]),
    .data_in  (wdata_q),
    .data_out (store_lanes)
  );

  lsu_align #(.XLEN(XLEN)) u_load_align (
    .store    (1'b0),
    .lane     (ea_q[LANE_W-1:0]),
    .size     (f3_q[1:0]),
    .uns      (f3_q[2]),
    .data_in  (mem_rdata_i),
    .data_out (load_lanes)
  );

  // Memory outputs are zero outside REQ so reset and idle present a quiet bus.
  assign in_req      = (state_q == REQ);
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && store_q;
  assign mem_addr_o  = in_req ? ADDR_W'({ea_q[XLEN-1:LANE_W], {LANE_W{1'b0}}}) : '0;
  assign mem_be_o    = in_req ? (size_be << ea_q[LANE_W-1:0]) : '0;
  assign mem_wdata_o = (in_req && store_q) ? store_lanes : '0;

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign wb_valid_o  = (state_q == RESP) && !exc_q && !store_q;
  assign done_o      = (state_q == RESP) && !exc_q && store_q;
  assign exc_o       = (state_q == RESP) && exc_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = rdata_q;
  assign exc_cause_o = cause_q;
  assign exc_addr_o  = ea_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: XLEN=32 instance for most scenarios and
// an XLEN=64 instance for wide-lane loads.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        req_valid = 0, req_load = 0, req_store = 0;
  logic [2:0]  req_f3 = 0;
  logic [31:0] req_base = 0, req_off = 0, req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        ready, mem_req, mem_we, wb_valid, done, exc, cause, busy;
  logic [31:0] mem_addr, mem_wdata, wb_data, exc_addr;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(ready),
    .req_load_i(req_load), .req_store_i(req_store), .req_funct3_i(req_f3),
    .req_base_i(req_base), .req_offset_i(req_off), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .done_o(done), .exc_o(exc), .exc_cause_o(cause), .exc_addr_o(exc_addr), .busy_o(busy)
  );

  // XLEN=64 instance
  logic        w_valid = 0, w_load = 0, w_store = 0;
  logic [2:0]  w_f3 = 0;
  logic [63:0] w_base = 0, w_off = 0, w_wdata = 0;
  logic [4:0]  w_rd = 0;
  logic        w_gnt = 0, w_rvalid = 0;
  logic [63:0] w_rdata = 0;
  logic        w_ready, w_mem_req, w_mem_we, w_wb_valid, w_done, w_exc, w_cause, w_busy;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata, w_wb_data, w_exc_addr;
  logic [7:0]  w_mem_be;
  logic [4:0]  w_wb_rd;

  load_store_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid_i(w_valid), .req_ready_o(w_ready),
    .req_load_i(w_load), .req_store_i(w_store), .req_funct3_i(w_f3),
    .req_base_i(w_base), .req_offset_i(w_off), .req_wdata_i(w_wdata), .req_rd_i(w_rd),
    .mem_req_o(w_mem_req), .mem_we_o(w_mem_we), .mem_addr_o(w_mem_addr), .mem_be_o(w_mem_be),
    .mem_wdata_o(w_mem_wdata), .mem_gnt_i(w_gnt), .mem_rvalid_i(w_rvalid), .mem_rdata_i(w_rdata),
    .wb_valid_o(w_wb_valid), .wb_rd_o(w_wb_rd), .wb_data_o(w_wb_data),
    .done_o(w_done), .exc_o(w_exc), .exc_cause_o(w_cause), .exc_addr_o(w_exc_addr), .busy_o(w_busy)
  );

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1; req_load = ld; req_store = st; req_f3 = f3;
    req_base = base; req_off = off; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_load = 0; req_store = 0;
  endtask

  task automatic test_reset;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({mem_req, mem_we, wb_valid, done, exc} !== 5'b0) begin errors++; $display("FAIL rst_pulses: got %b want 00000", {mem_req, mem_we, wb_valid, done, exc}); end
    checks++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin errors++; $display("FAIL rst_mem_bus: got %h/%h/%h want 0", mem_addr, mem_be, mem_wdata); end
    checks++; if ({wb_data, exc_addr, wb_rd, cause} !== 70'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0", wb_data, exc_addr); end
    checks++; if ({w_mem_req, w_busy, w_mem_wdata, w_wb_data} !== 130'h0) begin errors++; $display("FAIL rst_dut64: got req=%b busy=%b", w_mem_req, w_busy); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    drive_req(0, 1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd0);
    checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL sw_req_we: got %b want 11", {mem_req, mem_we}); end
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL sw_addr: got %h want 00000104", mem_addr); end
    checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", mem_be); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
    checks++; if ({ready, busy} !== 2'b01) begin errors++; $display("FAIL sw_busy: got ready/busy %b want 01", {ready, busy}); end
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    checks++; if ({done, mem_req, wb_valid, exc} !== 4'b1000) begin errors++; $display("FAIL sw_done: got done/req/wb/exc %b want 1000", {done, mem_req, wb_valid, exc}); end
    @(negedge clk);
    checks++; if ({done, ready} !== 2'b01) begin errors++; $display("FAIL sw_idle: got done/ready %b want 01", {done, ready}); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] off [6] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h0, 32'h1};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012, 32'h80123456, 32'h00000034};
    for (int i = 0; i < 6; i++) begin
      drive_req(1, 0, f3[i], 32'h200, off[i], 32'h0, 5'(i + 3));
      checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h200}) begin errors++; $display("FAIL ld%0d_req: got req/we %b addr %h want 10 00000200", i, {mem_req, mem_we}, mem_addr); end
      mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0;
      checks++; if ({mem_req, busy, wb_valid} !== 3'b010) begin errors++; $display("FAIL ld%0d_wait: got req/busy/wb %b want 010", i, {mem_req, busy, wb_valid}); end
      mem_rvalid = 1; mem_rdata = 32'h80123456;
      @(negedge clk);
      mem_rvalid = 0; mem_rdata = 32'h0;
      checks++; if ({wb_valid, done, exc} !== 3'b100) begin errors++; $display("FAIL ld%0d_wbv: got wb/done/exc %b want 100", i, {wb_valid, done, exc}); end
      checks++; if (wb_data !== exp[i]) begin errors++; $display("FAIL ld%0d_data: got %h want %h", i, wb_data, exp[i]); end
      checks++; if (wb_rd !== 5'(i + 3)) begin errors++; $display("FAIL ld%0d_rd: got %0d want %0d", i, wb_rd, i + 3); end
      @(negedge clk);
      checks++; if ({wb_valid, ready} !== 2'b01) begin errors++; $display("FAIL ld%0d_idle: got wb/ready %b want 01", i, {wb_valid, ready}); end
    end
  endtask

  task automatic test_store_lanes;
    drive_req(0, 1, 3'b000, 32'h200, 32'h2, 32'h000000AB, 5'd0);
    checks++; if (mem_be !== 4'b0100) begin errors++; $display("FAIL sb_be: got %b want 0100", mem_be); end
    checks++; if (mem_wdata[23:16] !== 8'hAB) begin errors++; $display("FAIL sb_wdata: got %h want ab in [23:16]", mem_wdata); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", mem_addr); end
    mem_gnt = 1; @(negedge clk); mem_gnt = 0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b want 1", done); end
    @(negedge clk);
    drive_req(0, 1, 3'b001, 32'h200, 32'h2, 32'h00001234, 5'd0);
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", mem_be); end
    checks++; if (mem_wdata[31:16] !== 16'h1234) begin errors++; $display("FAIL sh_wdata: got %h want 1234 in [31:16]", mem_wdata); end
    mem_gnt = 1; @(negedge clk); mem_gnt = 0;
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    drive_req(1, 0, 3'b001, 32'h200, 32'h1, 32'h0, 5'd1);
    checks++; if ({exc, mem_req, wb_valid, done} !== 4'b1000) begin errors++; $display("FAIL lh_mis_pulse: got exc/req/wb/done %b want 1000", {exc, mem_req, wb_valid, done}); end
    checks++; if (cause !== 1'b0) begin errors++; $display("FAIL lh_mis_cause: got %b want 0", cause); end
    checks++; if (exc_addr !== 32'h201) begin errors++; $display("FAIL lh_mis_addr: got %h want 00000201", exc_addr); end
    @(negedge clk);
    checks++; if ({exc, ready} !== 2'b01) begin errors++; $display("FAIL lh_mis_end: got exc/ready %b want 01", {exc, ready}); end
    drive_req(0, 1, 3'b010, 32'h100, 32'h2, 32'h1, 5'd0);
    checks++; if ({exc, cause, mem_req, done} !== 4'b1000) begin errors++; $display("FAIL sw_mis: got exc/cause/req/done %b want 1000", {exc, cause, mem_req, done}); end
    checks++; if (exc_addr !== 32'h102) begin errors++; $display("FAIL sw_mis_addr: got %h want 00000102", exc_addr); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic       ld [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       st [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] f3 [5] = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b010};
    for (int i = 0; i < 5; i++) begin
      drive_req(ld[i], st[i], f3[i], 32'h400, 32'h0, 32'h0, 5'd2);
      checks++; if ({exc, cause, mem_req, wb_valid, done} !== 5'b11000) begin errors++; $display("FAIL illegal%0d: got exc/cause/req/wb/done %b want 11000", i, {exc, cause, mem_req, wb_valid, done}); end
      @(negedge clk);
    end
  endtask

  task automatic test_no_op;
    req_valid = 1; mem_gnt = 1; mem_rvalid = 1;
    @(posedge clk); @(negedge clk);
    req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    checks++; if ({ready, busy, mem_req, wb_valid, done, exc} !== 6'b100000) begin errors++; $display("FAIL noop: got ready/busy/req/wb/done/exc %b want 100000", {ready, busy, mem_req, wb_valid, done, exc}); end
  endtask

  task automatic test_gnt_stall;
    drive_req(0, 1, 3'b010, 32'h108, 32'hFFFFFFFC, 32'h01020304, 5'd0);
    mem_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req, mem_we, ready, mem_addr, mem_be, mem_wdata} !== {3'b110, 32'h104, 4'hF, 32'h01020304}) begin errors++; $display("FAIL stall%0d: got req/we/ready %b addr %h be %b wdata %h want 110 00000104 1111 01020304", i, {mem_req, mem_we, ready}, mem_addr, mem_be, mem_wdata); end
      if (i < 3) @(negedge clk);
    end
    mem_gnt = 1; mem_rvalid = 0;
    @(negedge clk);
    mem_gnt = 0;
    checks++; if ({done, wb_valid} !== 2'b10) begin errors++; $display("FAIL stall_done: got done/wb %b want 10", {done, wb_valid}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    drive_req(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd7);
    mem_gnt = 1; @(negedge clk); mem_gnt = 0;
    checks++; if ({busy, mem_req} !== 2'b10) begin errors++; $display("FAIL rmid_wait: got busy/req %b want 10", {busy, mem_req}); end
    rst = 1;
    #1;
    checks++; if ({mem_req, busy, ready, wb_valid} !== 4'b0010) begin errors++; $display("FAIL rmid_async: got req/busy/ready/wb %b want 0010", {mem_req, busy, ready, wb_valid}); end
    @(negedge clk);
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_rvalid = 0;
    checks++; if ({wb_valid, busy, mem_req} !== 3'b000) begin errors++; $display("FAIL rmid_rvalid1: got wb/busy/req %b want 000", {wb_valid, busy, mem_req}); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_data} !== 33'h0) begin errors++; $display("FAIL rmid_rvalid2: got wb %b data %h want 0", wb_valid, wb_data); end
    drive_req(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd9);
    mem_gnt = 1; @(negedge clk); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h22222222; @(negedge clk); mem_rvalid = 0;
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 32'h22222222}) begin errors++; $display("FAIL rmid_next: got wb %b rd %0d data %h want 1 9 22222222", wb_valid, wb_rd, wb_data); end
    @(negedge clk);
  endtask

  task automatic test_xlen64;
    logic [2:0]  f3    [3] = '{3'b110, 3'b010, 3'b011};
    logic [63:0] off   [3] = '{64'h4, 64'h4, 64'h8};
    logic [63:0] rdata [3] = '{64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'h01234567_89ABCDEF};
    logic [63:0] exp   [3] = '{64'h00000000_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'h01234567_89ABCDEF};
    logic [31:0] addr  [3] = '{32'h1000, 32'h1000, 32'h1008};
    logic [7:0]  be    [3] = '{8'hF0, 8'hF0, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      w_valid = 1; w_load = 1; w_f3 = f3[i]; w_base = 64'h1000; w_off = off[i];
      @(posedge clk); @(negedge clk);
      w_valid = 0; w_load = 0;
      checks++; if ({w_mem_req, w_mem_addr, w_mem_be} !== {1'b1, addr[i], be[i]}) begin errors++; $display("FAIL x64_%0d_req: got req %b addr %h be %h want 1 %h %h", i, w_mem_req, w_mem_addr, w_mem_be, addr[i], be[i]); end
      w_gnt = 1; @(negedge clk); w_gnt = 0;
      w_rvalid = 1; w_rdata = rdata[i]; @(negedge clk); w_rvalid = 0;
      checks++; if ({w_wb_valid, w_wb_data} !== {1'b1, exp[i]}) begin errors++; $display("FAIL x64_%0d_data: got wb %b data %h want 1 %h", i, w_wb_valid, w_wb_data, exp[i]); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_lanes();
    test_misaligned();
    test_illegal();
    test_no_op();
    test_gnt_stall();
    test_reset_mid();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
